// File: rtl/rom_loader_if.sv
// ---------------------------------------------------------------------------
// rom_loader_if
//   Groups the byte-stream handshake and the instruction ROM port used by
//   rom_loader.
//   slave  : the loader side (consumes the stream, drives the ROM port)
//   master : the host/ROM side (drives the stream, returns ROM read data)
//   Signals:
//     s_valid/s_ready/s_data/s_last : byte stream, high byte of each word first
//     mem_adr/mem_we/mem_din        : ROM address, write strobe, write data
//     mem_dout                      : ROM read data, combinational from mem_adr
// ---------------------------------------------------------------------------
interface rom_loader_if #(
   parameter int ADR_W = 15
);
   logic             s_valid;
   logic             s_ready;
   logic [7:0]       s_data;
   logic             s_last;
   logic [ADR_W-1:0] mem_adr;
   logic             mem_we;
   logic [15:0]      mem_din;
   logic [15:0]      mem_dout;

   modport slave (
      input  s_valid, s_data, s_last, mem_dout,
      output s_ready, mem_adr, mem_we, mem_din
   );

   modport master (
      output s_valid, s_data, s_last, mem_dout,
      input  s_ready, mem_adr, mem_we, mem_din
   );
endinterface

// File: rtl/rom_loader.sv
// ---------------------------------------------------------------------------
// rom_loader
//   Loads the instruction ROM from a byte stream and shares the ROM address
//   port between the loader and the CPU fetch path. While a load is running
//   the CPU is held in reset and sees NOP; after the load (or after a system
//   reset) the CPU stays in reset for RST_HOLD more cycles before fetching.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     start        : one-cycle load request, honoured only when idle
//     cpu_pc       : CPU fetch address
//     cpu_instr    : instruction to the CPU (ROM data when idle, else 0)
//     cpu_reset    : CPU reset request
//     busy         : high whenever not idle
//     done         : one-cycle pulse when a load has fully finished
//     word_count   : words written by the current/last load
//     err          : bit0 odd byte count, bit1 ROM overflow (sticky)
//     bus          : byte stream and ROM port (rom_loader_if.slave)
// ---------------------------------------------------------------------------
module rom_loader #(
   parameter int ADR_W    = 15,
   parameter int BASE_ADR = 0,
   parameter int RST_HOLD = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [ADR_W-1:0] cpu_pc,
   output logic [15:0]      cpu_instr,
   output logic             cpu_reset,
   output logic             busy,
   output logic             done,
   output logic [ADR_W:0]   word_count,
   output logic [1:0]       err,
   rom_loader_if.slave      bus
);

   localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HI   = 3'd1,
      LO   = 3'd2,
      WR   = 3'd3,
      HOLD = 3'd4
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [ADR_W-1:0] ptr;
   logic [7:0]       hi_byte;
   logic             last_q;
   logic             loaded;
   logic             s_ready_q;
   logic             mem_we_q;
   logic [15:0]      mem_din_q;
   logic             hs;
   logic             at_top;
   logic             hold_end;

   assign hs       = bus.s_valid & s_ready_q;
   assign at_top   = (ptr == {ADR_W{1'b1}});
   assign hold_end = (cnt == CNT_W'(RST_HOLD - 1));

   // Address/instruction mux follows the current state so the CPU sees the
   // ROM the same cycle the FSM returns to IDLE.
   assign bus.mem_adr = (state == IDLE) ? cpu_pc : ptr;
   assign cpu_instr   = (state == IDLE) ? bus.mem_dout : 16'h0000;
   assign bus.s_ready = s_ready_q;
   assign bus.mem_we  = mem_we_q;
   assign bus.mem_din = mem_din_q;

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (start) state_n = HI;
         HI:   if (hs) state_n = bus.s_last ? HOLD : LO;
         LO:   if (hs) state_n = WR;
         // Overflow stops the load without consuming the remaining bytes.
         WR:   state_n = (last_q || at_top) ? HOLD : HI;
         HOLD: if (hold_end) state_n = IDLE;
         default: state_n = HOLD;
      endcase
   end

   // Registered outputs are derived from the next state so they line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HOLD;
         cnt        <= '0;
         s_ready_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_din_q  <= 16'h0000;
         done       <= 1'b0;
         word_count <= '0;
         err        <= 2'b00;
         cpu_reset  <= 1'b1;
         busy       <= 1'b1;
         loaded     <= 1'b0;
      end else begin
         state     <= state_n;
         s_ready_q <= (state_n == HI) || (state_n == LO);
         mem_we_q  <= (state_n == WR);
         cpu_reset <= (state_n != IDLE);
         busy      <= (state_n != IDLE);
         // done only marks the end of a real load, not the post-reset hold.
         done      <= (state == HOLD) && (state_n == IDLE) && loaded;
         cnt       <= ((state == HOLD) && (state_n == HOLD)) ? cnt + 1'b1 : '0;

         unique case (state)
            IDLE: begin
               if (start) begin
                  word_count <= '0;
                  err        <= 2'b00;
                  loaded     <= 1'b1;
               end
            end
            HI: begin
               if (hs && bus.s_last) err[0] <= 1'b1;
            end
            LO: begin
               if (hs) mem_din_q <= {hi_byte, bus.s_data};
            end
            WR: begin
               word_count <= word_count + 1'b1;
               if (!last_q && at_top) err[1] <= 1'b1;
            end
            HOLD: begin
               if (state_n == IDLE) loaded <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Datapath registers: no reset needed, always written before use.
   always_ff @(posedge clk) begin
      unique case (state)
         IDLE: if (start) ptr <= ADR_W'(BASE_ADR);
         HI:   if (hs) hi_byte <= bus.s_data;
         LO:   if (hs) last_q <= bus.s_last;
         WR:   if (!last_q && !at_top) ptr <= ptr + 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rom_loader.sv
module tb_rom_loader;
   localparam int ADR_W    = 15;
   localparam int RST_HOLD = 4;

   logic clk = 1'b0;
   logic reset, start1, start2;
   logic [ADR_W-1:0] cpu_pc1, cpu_pc2;
   logic [15:0] cpu_instr1, cpu_instr2;
   logic cpu_reset1, cpu_reset2, busy1, busy2, done1, done2;
   logic [ADR_W:0] wc1, wc2;
   logic [1:0] err1, err2;

   rom_loader_if #(.ADR_W(ADR_W)) bus1 ();
   rom_loader_if #(.ADR_W(ADR_W)) bus2 ();

   rom_loader #(.ADR_W(ADR_W), .BASE_ADR(0), .RST_HOLD(RST_HOLD)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .cpu_pc(cpu_pc1),
      .cpu_instr(cpu_instr1), .cpu_reset(cpu_reset1), .busy(busy1),
      .done(done1), .word_count(wc1), .err(err1), .bus(bus1.slave));

   rom_loader #(.ADR_W(ADR_W), .BASE_ADR(32766), .RST_HOLD(RST_HOLD)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .cpu_pc(cpu_pc2),
      .cpu_instr(cpu_instr2), .cpu_reset(cpu_reset2), .busy(busy2),
      .done(done2), .word_count(wc2), .err(err2), .bus(bus2.slave));

   always #5 clk = ~clk;

   logic [15:0] rom [0:32767];
   assign bus1.mem_dout = rom[bus1.mem_adr];
   assign bus2.mem_dout = 16'h0000;
   always @(posedge clk) if (bus1.mem_we) rom[bus1.mem_adr] <= bus1.mem_din;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int done_cyc = 0;
   int done_cnt1 = 0;
   int done_cnt2 = 0;
   logic [30:0] q1 [$];
   logic [30:0] q2 [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitors: every ROM write must match the next expected one.
   always @(negedge clk) begin
      if (bus1.mem_we) begin
         last_we_cyc = cyc;
         if (q1.size() == 0) check("dut1 unexpected write", {bus1.mem_adr, bus1.mem_din}, 64'hDEAD);
         else check("dut1 write", {bus1.mem_adr, bus1.mem_din}, q1.pop_front());
      end
      if (bus2.mem_we) begin
         if (q2.size() == 0) check("dut2 unexpected write", {bus2.mem_adr, bus2.mem_din}, 64'hDEAD);
         else check("dut2 write", {bus2.mem_adr, bus2.mem_din}, q2.pop_front());
      end
      if (done1) begin done_cnt1++; done_cyc = cyc; end
      if (done2) done_cnt2++;
   end

   task automatic pulse_start(input bit sel);
      @(negedge clk);
      if (sel) start2 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] d, input bit last, input int gap);
      int t;
      logic rdy;
      @(negedge clk);
      if (sel) begin bus2.s_valid = 1'b1; bus2.s_data = d; bus2.s_last = last; end
      else     begin bus1.s_valid = 1'b1; bus1.s_data = d; bus1.s_last = last; end
      t = 0;
      rdy = sel ? bus2.s_ready : bus1.s_ready;
      while (!rdy && t < 100) begin
         @(negedge clk);
         t++;
         rdy = sel ? bus2.s_ready : bus1.s_ready;
      end
      if (!rdy) check("s_ready timeout", 0, 1);
      @(posedge clk);
      #1;
      bus1.s_valid = 1'b0;
      bus2.s_valid = 1'b0;
      repeat (gap) @(posedge clk);
   endtask

   task automatic wait_done(input bit sel);
      int t;
      int c0;
      c0 = sel ? done_cnt2 : done_cnt1;
      t = 0;
      while ((sel ? done_cnt2 : done_cnt1) == c0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("done timeout", 0, 1);
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
      rom[5] = 16'hBEEF;
      reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
      cpu_pc1 = 15'd5; cpu_pc2 = '0;
      bus1.s_valid = 1'b0; bus1.s_data = 8'h00; bus1.s_last = 1'b0;
      bus2.s_valid = 1'b0; bus2.s_data = 8'h00; bus2.s_last = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;

      // 1: CPU held in reset RST_HOLD cycles after reset, then ROM passthrough
      for (int i = 0; i < RST_HOLD; i++) begin
         @(negedge clk);
         check("cpu_reset held", cpu_reset1, 1'b1);
      end
      @(negedge clk);
      check("cpu_reset released", cpu_reset1, 1'b0);
      check("busy idle", busy1, 1'b0);
      check("word_count reset", wc1, 0);
      check("err reset", err1, 2'b00);
      check("mem_adr passthrough", bus1.mem_adr, 15'd5);
      check("cpu_instr passthrough", cpu_instr1, 16'hBEEF);
      check("no done after reset", done_cnt1, 0);

      // 2: basic two-word load
      q1.push_back({15'd0, 16'h1234});
      q1.push_back({15'd1, 16'h5678});
      pulse_start(0);
      check("busy during load", busy1, 1'b1);
      check("cpu_instr NOP during load", cpu_instr1, 16'h0000);
      send_byte(0, 8'h12, 0, 0);
      send_byte(0, 8'h34, 0, 0);
      send_byte(0, 8'h56, 0, 0);
      send_byte(0, 8'h78, 1, 0);
      wait_done(0);
      // WR cycle, then RST_HOLD hold cycles, then the IDLE cycle carrying done
      check("done latency", done_cyc - last_we_cyc, RST_HOLD + 1);
      check("t2 word_count", wc1, 2);
      check("t2 err", err1, 2'b00);
      check("t2 cpu_reset low", cpu_reset1, 1'b0);
      cpu_pc1 = 15'd1;
      #1 check("t2 fetch loaded word", cpu_instr1, 16'h5678);

      // 3: s_valid gaps between bytes
      q1.push_back({15'd0, 16'h1234});
      q1.push_back({15'd1, 16'h5678});
      pulse_start(0);
      send_byte(0, 8'h12, 0, 1);
      send_byte(0, 8'h34, 0, 1);
      send_byte(0, 8'h56, 0, 1);
      send_byte(0, 8'h78, 1, 1);
      wait_done(0);
      check("t3 word_count", wc1, 2);
      check("t3 err", err1, 2'b00);

      // 4: odd byte count
      q1.push_back({15'd0, 16'hAABB});
      pulse_start(0);
      send_byte(0, 8'hAA, 0, 0);
      send_byte(0, 8'hBB, 0, 0);
      send_byte(0, 8'hCC, 1, 0);
      wait_done(0);
      check("t4 err odd", err1, 2'b01);
      check("t4 word_count", wc1, 1);
      @(negedge clk);
      check("t4 idle", busy1, 1'b0);

      // 6: reset in LO after one word, then reload
      q1.push_back({15'd0, 16'h1234});
      pulse_start(0);
      send_byte(0, 8'h12, 0, 0);
      send_byte(0, 8'h34, 0, 0);
      send_byte(0, 8'h56, 0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("t6 word_count cleared", wc1, 0);
      check("t6 cpu_reset after abort", cpu_reset1, 1'b1);
      check("t6 s_ready after abort", bus1.s_ready, 1'b0);
      repeat (RST_HOLD + 2) @(negedge clk);
      check("t6 idle after abort", busy1, 1'b0);
      q1.push_back({15'd0, 16'h9ABC});
      pulse_start(0);
      send_byte(0, 8'h9A, 0, 0);
      send_byte(0, 8'hBC, 1, 0);
      wait_done(0);
      check("t6 reload word_count", wc1, 1);

      // 5: overflow at top of ROM (second instance, BASE_ADR=32766)
      q2.push_back({15'd32766, 16'h0102});
      q2.push_back({15'd32767, 16'h0304});
      pulse_start(1);
      send_byte(1, 8'h01, 0, 0);
      send_byte(1, 8'h02, 0, 0);
      send_byte(1, 8'h03, 0, 0);
      send_byte(1, 8'h04, 0, 0);
      wait_done(1);
      check("t5 err overflow", err2, 2'b10);
      check("t5 word_count", wc2, 2);
      begin
         int rdy_seen;
         rdy_seen = 0;
         @(negedge clk);
         bus2.s_valid = 1'b1; bus2.s_data = 8'h05; bus2.s_last = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus2.s_ready) rdy_seen++;
         end
         bus2.s_valid = 1'b0;
         check("t5 s_ready low after overflow", rdy_seen, 0);
      end

      repeat (3) @(negedge clk);
      check("dut1 writes outstanding", q1.size(), 0);
      check("dut2 writes outstanding", q2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1);
   end
endmodule
